issue_decode_buffer: RTL and testbench

// - Decode/issue stage behind IF: buffers up to DEPTH fetched RV32I instructions in a FIFO.
// - Decodes the head entry, then resolves rs1/rs2 through regfile, ROB and NUM_CDB broadcast channels.
// - Issues one registered packet per cycle to the ROB, the RS or the LSB.
// - Adds stall on downstream full, flush on mispredict and an illegal-op flag.

---
 rtl/issue_decode_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_issue_decode_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_decode_buffer.sv
// -----------------------------------------------------------------------------
// issue_decode_buffer
//   Decode/issue stage sitting behind instruction fetch. Fetched RV32I words are
//   queued in a small FIFO; the head entry is decoded, its source operands are
//   resolved through the regfile, the ROB and the CDB broadcast channels, and a
//   single registered issue packet is produced per cycle for the RS or the LSB.
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (global enable), flush_in
//   if_valid/if_inst/if_pc          : fetch push interface, dc_full back-pressure
//   rs1_pos/rs2_pos                 : regfile read indices of the head entry
//   rs*_val/rs*_dep                 : regfile value and rename tag
//   rob_rs*_ready/rob_rs*_val       : ROB lookup of the rename tag
//   cdb_valid/cdb_idx/cdb_val       : NUM_CDB broadcast channels
//   rob_full/rs_full/lsb_full       : downstream occupancy
//   issue_*                         : registered issue packet (1-cycle valid)
//
// Operation codes on issue_op (0 = illegal):
//   1 LUI 2 AUIPC 3 JAL 4 JALR 5..10 BEQ BNE BLT BGE BLTU BGEU
//   11..15 LB LH LW LBU LHU 16..18 SB SH SW
//   19..27 ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
//   28..37 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
// -----------------------------------------------------------------------------
module issue_decode_buffer #(
   parameter int DEPTH     = 4,
   parameter int NUM_CDB   = 2,
   parameter int ROB_IDX_W = 4
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         rdy_in,
   input  logic                         flush_in,
   input  logic                         if_valid,
   input  logic [31:0]                  if_inst,
   input  logic [31:0]                  if_pc,
   output logic                         dc_full,
   output logic [4:0]                   rs1_pos,
   output logic [4:0]                   rs2_pos,
   input  logic [31:0]                  rs1_val,
   input  logic [31:0]                  rs2_val,
   input  logic [ROB_IDX_W-1:0]         rs1_dep,
   input  logic [ROB_IDX_W-1:0]         rs2_dep,
   input  logic                         rob_rs1_ready,
   input  logic                         rob_rs2_ready,
   input  logic [31:0]                  rob_rs1_val,
   input  logic [31:0]                  rob_rs2_val,
   input  logic [NUM_CDB-1:0]           cdb_valid,
   input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_idx,
   input  logic [NUM_CDB*32-1:0]        cdb_val,
   input  logic                         rob_full,
   input  logic                         rs_full,
   input  logic                         lsb_full,
   output logic                         issue_valid,
   output logic [5:0]                   issue_op,
   output logic [31:0]                  issue_rs1_val,
   output logic [31:0]                  issue_rs2_val,
   output logic [ROB_IDX_W-1:0]         issue_rs1_dep,
   output logic [ROB_IDX_W-1:0]         issue_rs2_dep,
   output logic [4:0]                   issue_rd,
   output logic [31:0]                  issue_imm,
   output logic [31:0]                  issue_pc,
   output logic                         issue_to_lsb,
   output logic                         issue_to_rs,
   output logic                         issue_illegal
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW:0] PTR_ONE  = (PW+1)'(1);

   localparam logic [6:0] OPC_LUI   = 7'h37;
   localparam logic [6:0] OPC_AUIPC = 7'h17;
   localparam logic [6:0] OPC_JAL   = 7'h6F;
   localparam logic [6:0] OPC_JALR  = 7'h67;
   localparam logic [6:0] OPC_BR    = 7'h63;
   localparam logic [6:0] OPC_LD    = 7'h03;
   localparam logic [6:0] OPC_ST    = 7'h23;
   localparam logic [6:0] OPC_OPI   = 7'h13;
   localparam logic [6:0] OPC_OP    = 7'h33;

   // ---------------------------------------------------------------- FIFO ----
   logic [31:0] inst_q [DEPTH];
   logic [31:0] pc_q   [DEPTH];
   logic [PW:0] rd_ptr_q, wr_ptr_q;
   logic [PW:0] count;
   logic        empty;
   logic        wr_en;
   logic [31:0] head;

   // The extra pointer MSB distinguishes full from empty when the low bits match.
   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty   = (count == '0);
   assign dc_full = (count == FULL_CNT);
   assign head    = inst_q[rd_ptr_q[PW-1:0]];
   assign rs1_pos = head[19:15];
   assign rs2_pos = head[24:20];

   // Full is judged on the current count, so a pop in the same cycle does not
   // open a slot for the incoming word. Flush discards the incoming word too.
   assign wr_en = rst_in && rdy_in && !flush_in && if_valid && !dc_full;

   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         inst_q[wr_ptr_q[PW-1:0]] <= if_inst;
         pc_q[wr_ptr_q[PW-1:0]]   <= if_pc;
      end
   end

   // -------------------------------------------------------------- decode ----
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [5:0]  dec_op;
   logic [31:0] dec_imm;
   logic        dec_legal, dec_lsb, use_rs1, use_rs2, rd_en;
   logic [4:0]  dec_rd;

   assign opc = head[6:0];
   assign f3  = head[14:12];
   assign f7  = head[31:25];

   assign imm_i = {{21{head[31]}}, head[30:20]};
   assign imm_s = {{21{head[31]}}, head[30:25], head[11:7]};
   assign imm_b = {{20{head[31]}}, head[7], head[30:25], head[11:8], 1'b0};
   assign imm_u = {head[31:12], 12'b0};
   assign imm_j = {{12{head[31]}}, head[19:12], head[20], head[30:21], 1'b0};

   always_comb begin
      dec_op    = 6'd0;
      dec_imm   = '0;
      dec_legal = 1'b0;
      dec_lsb   = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      rd_en     = 1'b0;
      case (opc)
         OPC_LUI: begin
            dec_op = 6'd1; dec_legal = 1'b1; dec_imm = imm_u; rd_en = 1'b1;
         end
         OPC_AUIPC: begin
            dec_op = 6'd2; dec_legal = 1'b1; dec_imm = imm_u; rd_en = 1'b1;
         end
         OPC_JAL: begin
            dec_op = 6'd3; dec_legal = 1'b1; dec_imm = imm_j; rd_en = 1'b1;
         end
         OPC_JALR: begin
            dec_op = 6'd4; dec_legal = (f3 == 3'd0); dec_imm = imm_i;
            use_rs1 = 1'b1; rd_en = 1'b1;
         end
         OPC_BR: begin
            dec_legal = 1'b1; dec_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (f3)
               3'd0:    dec_op = 6'd5;
               3'd1:    dec_op = 6'd6;
               3'd4:    dec_op = 6'd7;
               3'd5:    dec_op = 6'd8;
               3'd6:    dec_op = 6'd9;
               3'd7:    dec_op = 6'd10;
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_LD: begin
            dec_legal = 1'b1; dec_imm = imm_i; dec_lsb = 1'b1;
            use_rs1 = 1'b1; rd_en = 1'b1;
            case (f3)
               3'd0:    dec_op = 6'd11;
               3'd1:    dec_op = 6'd12;
               3'd2:    dec_op = 6'd13;
               3'd4:    dec_op = 6'd14;
               3'd5:    dec_op = 6'd15;
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_ST: begin
            dec_legal = 1'b1; dec_imm = imm_s; dec_lsb = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (f3)
               3'd0:    dec_op = 6'd16;
               3'd1:    dec_op = 6'd17;
               3'd2:    dec_op = 6'd18;
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_OPI: begin
            dec_legal = 1'b1; dec_imm = imm_i; use_rs1 = 1'b1; rd_en = 1'b1;
            case (f3)
               3'd0: dec_op = 6'd19;
               3'd2: dec_op = 6'd20;
               3'd3: dec_op = 6'd21;
               3'd4: dec_op = 6'd22;
               3'd6: dec_op = 6'd23;
               3'd7: dec_op = 6'd24;
               3'd1: begin
                  dec_op = 6'd25; dec_legal = (f7 == 7'h00);
               end
               default: begin
                  // f3 == 5: the upper immediate bits select logical/arith shift
                  dec_op    = (f7 == 7'h20) ? 6'd27 : 6'd26;
                  dec_legal = (f7 == 7'h00) || (f7 == 7'h20);
               end
            endcase
         end
         OPC_OP: begin
            dec_legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; rd_en = 1'b1;
            case ({f7, f3})
               10'h000: dec_op = 6'd28;
               10'h100: dec_op = 6'd29;
               10'h001: dec_op = 6'd30;
               10'h002: dec_op = 6'd31;
               10'h003: dec_op = 6'd32;
               10'h004: dec_op = 6'd33;
               10'h005: dec_op = 6'd34;
               10'h105: dec_op = 6'd35;
               10'h006: dec_op = 6'd36;
               10'h007: dec_op = 6'd37;
               default: dec_legal = 1'b0;
            endcase
         end
         default: ;
      endcase
      // Illegal words travel to the RS as an empty shell; the ROB traps on them.
      if (!dec_legal) begin
         dec_op  = 6'd0;
         dec_imm = '0;
         dec_lsb = 1'b0;
         use_rs1 = 1'b0;
         use_rs2 = 1'b0;
         rd_en   = 1'b0;
      end
   end

   assign dec_rd = rd_en ? head[11:7] : 5'd0;

   // ----------------------------------------------------- operand resolve ----
   // Returns {dep, val}. For the CDB scan the loop runs high-to-low so that the
   // lowest-numbered matching channel is the one left standing.
   function automatic logic [ROB_IDX_W+31:0] resolve(
      input logic [ROB_IDX_W-1:0]         dep,
      input logic [31:0]                  rf_v,
      input logic                         rob_rdy,
      input logic [31:0]                  rob_v,
      input logic [NUM_CDB-1:0]           cv,
      input logic [NUM_CDB*ROB_IDX_W-1:0] ci,
      input logic [NUM_CDB*32-1:0]        cval
   );
      logic [ROB_IDX_W+31:0] r;
      r = {dep, 32'd0};
      if (dep == '0) begin
         r = {{ROB_IDX_W{1'b0}}, rf_v};
      end else if (rob_rdy) begin
         r = {{ROB_IDX_W{1'b0}}, rob_v};
      end else begin
         for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cv[k] && (ci[k*ROB_IDX_W +: ROB_IDX_W] == dep))
               r = {{ROB_IDX_W{1'b0}}, cval[k*32 +: 32]};
         end
      end
      return r;
   endfunction

   logic [ROB_IDX_W+31:0] res1, res2;

   always_comb begin
      res1 = '0;
      res2 = '0;
      if (use_rs1)
         res1 = resolve(rs1_dep, rs1_val, rob_rs1_ready, rob_rs1_val,
                        cdb_valid, cdb_idx, cdb_val);
      if (use_rs2)
         res2 = resolve(rs2_dep, rs2_val, rob_rs2_ready, rob_rs2_val,
                        cdb_valid, cdb_idx, cdb_val);
   end

   // --------------------------------------------------------------- issue ----
   logic go;
   assign go = !empty && !flush_in && !rob_full && !(dec_lsb ? lsb_full : rs_full);

   logic                 valid_q, to_lsb_q, to_rs_q, illegal_q;
   logic [5:0]           op_q;
   logic [31:0]          v1_q, v2_q, imm_q, pc_o_q;
   logic [ROB_IDX_W-1:0] d1_q, d2_q;
   logic [4:0]           rd_q;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         valid_q   <= 1'b0;
         op_q      <= '0;
         v1_q      <= '0;
         v2_q      <= '0;
         d1_q      <= '0;
         d2_q      <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         pc_o_q    <= '0;
         to_lsb_q  <= 1'b0;
         to_rs_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else if (!rdy_in) begin
         // Frozen; the pulse already presented is not stretched.
         valid_q <= 1'b0;
      end else if (flush_in) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         valid_q <= go;
         if (go) begin
            rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            op_q      <= dec_op;
            d1_q      <= res1[ROB_IDX_W+31:32];
            v1_q      <= res1[31:0];
            d2_q      <= res2[ROB_IDX_W+31:32];
            v2_q      <= res2[31:0];
            rd_q      <= dec_rd;
            imm_q     <= dec_imm;
            pc_o_q    <= pc_q[rd_ptr_q[PW-1:0]];
            to_lsb_q  <= dec_lsb;
            to_rs_q   <= !dec_lsb;
            illegal_q <= !dec_legal;
         end
      end
   end

   assign issue_valid   = valid_q;
   assign issue_op      = op_q;
   assign issue_rs1_val = v1_q;
   assign issue_rs2_val = v2_q;
   assign issue_rs1_dep = d1_q;
   assign issue_rs2_dep = d2_q;
   assign issue_rd      = rd_q;
   assign issue_imm     = imm_q;
   assign issue_pc      = pc_o_q;
   assign issue_to_lsb  = to_lsb_q;
   assign issue_to_rs   = to_rs_q;
   assign issue_illegal = illegal_q;

endmodule

// File: tb/tb_issue_decode_buffer.sv
module tb_issue_decode_buffer;
   localparam int DEPTH = 4;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, flush_in, if_valid;
   logic [31:0] if_inst, if_pc;
   logic        dc_full;
   logic [4:0]  rs1_pos, rs2_pos;
   logic [31:0] rs1_val, rs2_val, rob_rs1_val, rob_rs2_val;
   logic [3:0]  rs1_dep, rs2_dep;
   logic        rob_rs1_ready, rob_rs2_ready;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_idx;
   logic [63:0] cdb_val;
   logic        rob_full, rs_full, lsb_full;
   logic        issue_valid, issue_to_lsb, issue_to_rs, issue_illegal;
   logic [5:0]  issue_op;
   logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
   logic [3:0]  issue_rs1_dep, issue_rs2_dep;
   logic [4:0]  issue_rd;

   issue_decode_buffer #(.DEPTH(DEPTH), .NUM_CDB(2), .ROB_IDX_W(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .dc_full(dc_full),
      .rs1_pos(rs1_pos), .rs2_pos(rs2_pos), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .rs1_dep(rs1_dep), .rs2_dep(rs2_dep),
      .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
      .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
      .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
      .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
      .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
      .issue_rs1_dep(issue_rs1_dep), .issue_rs2_dep(issue_rs2_dep),
      .issue_rd(issue_rd), .issue_imm(issue_imm), .issue_pc(issue_pc),
      .issue_to_lsb(issue_to_lsb), .issue_to_rs(issue_to_rs),
      .issue_illegal(issue_illegal)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   typedef struct packed {
      logic [5:0]  op;
      logic        ill;
      logic        lsb;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] v1;
      logic [3:0]  d1;
      logic [31:0] v2;
      logic [3:0]  d2;
   } pkt_t;

   ent_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [18:0] tbl [37];   // {opcode, f3 care, f3, f7 care, f7}; op code = index+1

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [18:0] t(input logic [6:0] o, input bit c3, input logic [2:0] f3,
                                     input bit c7, input logic [6:0] f7);
      return {o, c3, f3, c7, f7};
   endfunction

   function automatic logic [5:0] lookup(input logic [31:0] inst);
      for (int i = 0; i < 37; i++) begin
         if (tbl[i][18:12] == inst[6:0] &&
             (!tbl[i][11] || tbl[i][10:8] == inst[14:12]) &&
             (!tbl[i][7]  || tbl[i][6:0]  == inst[31:25]))
            return 6'(i + 1);
      end
      return 6'd0;
   endfunction

   // Rename resolution: regfile, then ROB, then the first matching CDB channel.
   function automatic void res(input logic [3:0] dep, input logic [31:0] rf, input logic rr,
                               input logic [31:0] rv, output logic [31:0] v, output logic [3:0] d);
      v = 0; d = dep;
      if (dep == 0) v = rf;
      else if (rr) begin v = rv; d = 0; end
      else begin
         for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] && cdb_idx[k*4 +: 4] == dep) begin
               v = cdb_val[k*32 +: 32]; d = 0; break;
            end
         end
      end
   endfunction

   function automatic pkt_t model(input logic [31:0] inst);
      pkt_t p;
      logic [6:0] o;
      logic use1, use2;
      p = '0;
      o = inst[6:0];
      p.op  = lookup(inst);
      p.ill = (p.op == 0);
      if (p.ill) return p;
      p.lsb = (o == 7'h03 || o == 7'h23);
      p.rd  = (o == 7'h63 || o == 7'h23) ? 5'd0 : inst[11:7];
      case (o)
         7'h13, 7'h03, 7'h67: p.imm = 32'($signed(inst) >>> 20);
         7'h23: p.imm = 32'(($signed(inst) >>> 25) << 5) | ((inst >> 7) & 32'd31);
         7'h63: p.imm = 32'(($signed(inst) >>> 31) << 12) | (((inst >> 7) & 1) << 11)
                      | (((inst >> 25) & 63) << 5) | (((inst >> 8) & 15) << 1);
         7'h37, 7'h17: p.imm = inst & 32'hFFFFF000;
         7'h6F: p.imm = 32'(($signed(inst) >>> 31) << 20) | (inst & 32'h000FF000)
                      | (((inst >> 20) & 1) << 11) | (((inst >> 21) & 1023) << 1);
         default: p.imm = 0;
      endcase
      use1 = !(o == 7'h37 || o == 7'h17 || o == 7'h6F);
      use2 = (o == 7'h63 || o == 7'h23 || o == 7'h33);
      if (use1) res(rs1_dep, rs1_val, rob_rs1_ready, rob_rs1_val, p.v1, p.d1);
      if (use2) res(rs2_dep, rs2_val, rob_rs2_ready, rob_rs2_val, p.v2, p.d2);
      return p;
   endfunction

   // One clock: check comb outputs, predict, clock, check registered outputs.
   task automatic step();
      pkt_t e;
      logic go, acc;
      e = '0; go = 0; acc = 0;
      #2;
      if (rst_in) begin
         chk("dc_full", dc_full, q.size() == DEPTH);
         if (q.size() > 0) begin
            chk("rs1_pos", rs1_pos, q[0].inst[19:15]);
            chk("rs2_pos", rs2_pos, q[0].inst[24:20]);
         end
      end
      if (rst_in && rdy_in && !flush_in) begin
         if (q.size() > 0) begin
            e  = model(q[0].inst);
            go = !rob_full && !(e.lsb ? lsb_full : rs_full);
         end
         acc = if_valid && (q.size() < DEPTH);
      end
      @(posedge clk_in); #1;
      if (!rst_in) begin
         q.delete();
         chk("rst_valid", issue_valid, 0);   chk("rst_op", issue_op, 0);
         chk("rst_rd", issue_rd, 0);         chk("rst_imm", issue_imm, 0);
         chk("rst_pc", issue_pc, 0);         chk("rst_v1", issue_rs1_val, 0);
         chk("rst_v2", issue_rs2_val, 0);    chk("rst_d1", issue_rs1_dep, 0);
         chk("rst_d2", issue_rs2_dep, 0);    chk("rst_lsb", issue_to_lsb, 0);
         chk("rst_rs", issue_to_rs, 0);      chk("rst_ill", issue_illegal, 0);
      end else if (!rdy_in) begin
         chk("frozen_valid", issue_valid, 0);
      end else if (flush_in) begin
         q.delete();
         chk("flush_valid", issue_valid, 0);
      end else begin
         chk("issue_valid", issue_valid, go);
         if (go) begin
            chk("op", issue_op, e.op);
            chk("illegal", issue_illegal, e.ill);
            chk("to_lsb", issue_to_lsb, e.lsb);
            chk("to_rs", issue_to_rs, !e.lsb);
            chk("pc", issue_pc, q[0].pc);
            if (!e.ill) begin
               chk("rd", issue_rd, e.rd);
               chk("imm", issue_imm, e.imm);
               chk("rs1_val", issue_rs1_val, e.v1);
               chk("rs1_dep", issue_rs1_dep, e.d1);
               chk("rs2_val", issue_rs2_val, e.v2);
               chk("rs2_dep", issue_rs2_dep, e.d2);
            end
            void'(q.pop_front());
         end
         if (acc) q.push_back('{if_inst, if_pc});
      end
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] pc);
      if_valid = 1; if_inst = inst; if_pc = pc;
      step();
      if_valid = 0;
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6F;  3: r[6:0] = 7'h67;
         4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;  6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;
         8: r[6:0] = 7'h33;  default: r[6:0] = 7'h7F;
      endcase
      case ($urandom_range(0, 3))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      tbl[0]  = t(7'h37,0,0,0,0); tbl[1]  = t(7'h17,0,0,0,0); tbl[2]  = t(7'h6F,0,0,0,0);
      tbl[3]  = t(7'h67,1,0,0,0);
      tbl[4]  = t(7'h63,1,0,0,0); tbl[5]  = t(7'h63,1,1,0,0); tbl[6]  = t(7'h63,1,4,0,0);
      tbl[7]  = t(7'h63,1,5,0,0); tbl[8]  = t(7'h63,1,6,0,0); tbl[9]  = t(7'h63,1,7,0,0);
      tbl[10] = t(7'h03,1,0,0,0); tbl[11] = t(7'h03,1,1,0,0); tbl[12] = t(7'h03,1,2,0,0);
      tbl[13] = t(7'h03,1,4,0,0); tbl[14] = t(7'h03,1,5,0,0);
      tbl[15] = t(7'h23,1,0,0,0); tbl[16] = t(7'h23,1,1,0,0); tbl[17] = t(7'h23,1,2,0,0);
      tbl[18] = t(7'h13,1,0,0,0); tbl[19] = t(7'h13,1,2,0,0); tbl[20] = t(7'h13,1,3,0,0);
      tbl[21] = t(7'h13,1,4,0,0); tbl[22] = t(7'h13,1,6,0,0); tbl[23] = t(7'h13,1,7,0,0);
      tbl[24] = t(7'h13,1,1,1,0); tbl[25] = t(7'h13,1,5,1,0); tbl[26] = t(7'h13,1,5,1,7'h20);
      tbl[27] = t(7'h33,1,0,1,0); tbl[28] = t(7'h33,1,0,1,7'h20); tbl[29] = t(7'h33,1,1,1,0);
      tbl[30] = t(7'h33,1,2,1,0); tbl[31] = t(7'h33,1,3,1,0); tbl[32] = t(7'h33,1,4,1,0);
      tbl[33] = t(7'h33,1,5,1,0); tbl[34] = t(7'h33,1,5,1,7'h20); tbl[35] = t(7'h33,1,6,1,0);
      tbl[36] = t(7'h33,1,7,1,0);

      rdy_in = 1; flush_in = 0; rob_full = 0; rs_full = 0; lsb_full = 0;
      rs1_val = 0; rs2_val = 0; rs1_dep = 0; rs2_dep = 0;
      rob_rs1_ready = 0; rob_rs2_ready = 0; rob_rs1_val = 0; rob_rs2_val = 0;
      cdb_valid = 0; cdb_idx = 0; cdb_val = 0;

      // Reset held two cycles while fetch keeps pushing.
      rst_in = 0; if_valid = 1; if_inst = 32'h00000013; if_pc = 32'h40;
      step(); step();
      rst_in = 1; if_valid = 0;
      chk("reset_dc_full", dc_full, 0);
      step();
      chk("reset_empty", issue_valid, 0);

      // ADDI x5,x1,-1 from the regfile.
      push(32'hFFF08293, 32'h100);
      rs1_dep = 0; rs1_val = 7;
      step();
      chk("addi_valid", issue_valid, 1); chk("addi_op", issue_op, 19);
      chk("addi_imm", issue_imm, 32'hFFFFFFFF); chk("addi_v1", issue_rs1_val, 7);
      chk("addi_rd", issue_rd, 5); chk("addi_to_rs", issue_to_rs, 1);

      // CDB forwarding: lowest channel wins; no match keeps the tag.
      push(32'hFFF08293, 32'h104);
      rs1_dep = 3; rob_rs1_ready = 0; cdb_valid = 2'b11; cdb_idx = 8'h33;
      cdb_val = {32'h22, 32'h11};
      step();
      chk("cdb_v1", issue_rs1_val, 32'h11); chk("cdb_d1", issue_rs1_dep, 0);
      push(32'hFFF08293, 32'h108);
      cdb_idx = 8'h55;
      step();
      chk("nocdb_d1", issue_rs1_dep, 3); chk("nocdb_v1", issue_rs1_val, 0);
      rs1_dep = 0; cdb_valid = 0;

      // SW x2,-4(x1) held behind a full LSB.
      lsb_full = 1;
      push(32'hFE20AE23, 32'h10C);
      for (int i = 0; i < 3; i++) step();
      chk("sw_held", issue_valid, 0);
      lsb_full = 0;
      step();
      chk("sw_valid", issue_valid, 1); chk("sw_imm", issue_imm, 32'hFFFFFFFC);
      chk("sw_rd", issue_rd, 0); chk("sw_lsb", issue_to_lsb, 1); chk("sw_op", issue_op, 18);

      // Fill to DEPTH behind rob_full, overflow dropped, order across wrap.
      rob_full = 1;
      for (int i = 0; i < DEPTH; i++) push(32'h00000013 | (i << 7), 32'h200 + 4 * i);
      chk("fill_dc_full", dc_full, 1);
      push(32'h00000013, 32'h2FC);
      rob_full = 0;
      for (int i = 0; i < DEPTH; i++) begin
         step();
         chk("order_pc", issue_pc, 32'h200 + 4 * i);
      end
      step();
      chk("overflow_dropped", issue_valid, 0);

      // Flush with entries queued and a concurrent push.
      rob_full = 1;
      for (int i = 0; i < 3; i++) push(32'h00000013, 32'h300 + 4 * i);
      flush_in = 1; if_valid = 1; if_inst = 32'h00000013; if_pc = 32'h3F0;
      step();
      chk("flush_valid1", issue_valid, 0);
      flush_in = 0; if_valid = 0; rob_full = 0;
      step();
      chk("flush_empty", issue_valid, 0); chk("flush_dc_full", dc_full, 0);

      // Unknown opcode goes to the RS flagged illegal.
      push(32'h0000007F, 32'h400);
      step();
      chk("ill_flag", issue_illegal, 1); chk("ill_op", issue_op, 0);
      chk("ill_to_rs", issue_to_rs, 1);

      // Global enable low blocks both push and issue.
      rdy_in = 0;
      push(32'h00000013, 32'h500);
      rdy_in = 1;
      step();
      chk("rdy_blocked", issue_valid, 0);

      // Randomised traffic against the queue model.
      for (int c = 0; c < 600; c++) begin
         if_valid = ($urandom_range(0, 1) == 1); if_inst = rnd_inst(); if_pc = $urandom;
         flush_in = ($urandom_range(0, 24) == 0);
         rdy_in   = ($urandom_range(0, 9) != 0);
         rob_full = ($urandom_range(0, 4) == 0);
         rs_full  = ($urandom_range(0, 4) == 0);
         lsb_full = ($urandom_range(0, 4) == 0);
         rs1_dep = 4'($urandom_range(0, 3)); rs2_dep = 4'($urandom_range(0, 3));
         rs1_val = $urandom; rs2_val = $urandom;
         rob_rs1_ready = ($urandom_range(0, 2) == 0); rob_rs2_ready = ($urandom_range(0, 2) == 0);
         rob_rs1_val = $urandom; rob_rs2_val = $urandom;
         cdb_valid = 2'($urandom_range(0, 3));
         cdb_idx = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
         cdb_val = {$urandom, $urandom};
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
